// File: rtl/riscv_rf_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package riscv_rf_pkg;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_e;

    // Address width for a register count; never narrower than one bit.
    function automatic int unsigned rf_addr_width(input int unsigned nreg);
        return (nreg > 2) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Per-register pending-write bits: set on issue, cleared by the committing write.
module riscv_rf_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned NRP  = 2,
    localparam int unsigned AW  = rf_addr_width(NREG)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              set_en_i,
    input  logic [AW-1:0]     set_addr_i,
    input  logic              clr0_en_i,
    input  logic [AW-1:0]     clr0_addr_i,
    input  logic              clr1_en_i,
    input  logic [AW-1:0]     clr1_addr_i,
    input  logic [NRP*AW-1:0] rd_addr_i,
    output logic [NRP-1:0]    rd_busy_o
);

    logic [NREG-1:0] busy_q, busy_d;

    // Set is applied last so a same-cycle set and clear leaves the bit pending.
    always_comb begin
        busy_d = busy_q;
        if (clr0_en_i) busy_d[clr0_addr_i] = 1'b0;
        if (clr1_en_i) busy_d[clr1_addr_i] = 1'b0;
        if (set_en_i)  busy_d[set_addr_i]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_busy_o = '0;
        for (int p = 0; p < NRP; p++) begin
            rd_busy_o[p] = busy_q[rd_addr_i[p*AW +: AW]];
        end
    end

endmodule

// File: rtl/riscv_reg_file_mp.sv
// Multi-port integer register file with two write ports, an init sweep and a
// pending-write scoreboard.
module riscv_reg_file_mp
    import riscv_rf_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned NRP    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = rf_addr_width(NREG)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRP*AW-1:0]   rd_addr_i,
    output logic [NRP*XLEN-1:0] rd_data_o,
    output logic [NRP-1:0]      rd_busy_o,
    input  logic                wr0_en_i,
    input  logic [AW-1:0]       wr0_addr_i,
    input  logic [XLEN-1:0]     wr0_data_i,
    input  logic                wr1_en_i,
    input  logic [AW-1:0]       wr1_addr_i,
    input  logic [XLEN-1:0]     wr1_data_i,
    input  logic                sb_set_en_i,
    input  logic [AW-1:0]       sb_set_addr_i,
    output logic                ready_o
);

    rf_state_e       state_q;
    logic [AW-1:0]   idx_q;
    logic            ready_q;
    logic [XLEN-1:0] mem_q [NREG];

    logic run;
    logic wr0_act, wr1_act;

    assign run     = (state_q == RF_RUN);
    assign wr0_act = rstn && run && wr0_en_i && (wr0_addr_i != '0);
    assign wr1_act = rstn && run && wr1_en_i && (wr1_addr_i != '0);
    assign ready_o = ready_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= RF_INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                RF_INIT: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == AW'(NREG - 1)) begin
                        state_q <= RF_RUN;
                        ready_q <= 1'b1;
                    end
                end
                RF_RUN: state_q <= RF_RUN;
            endcase
        end
    end

    // No reset on storage: entries are cleared one per cycle by the sweep so the
    // array stays RAM-inferable. wr1 is written last so it wins on a collision.
    always_ff @(posedge clk) begin
        if (rstn && !run) begin
            mem_q[idx_q] <= '0;
        end else begin
            if (wr0_act) mem_q[wr0_addr_i] <= wr0_data_i;
            if (wr1_act) mem_q[wr1_addr_i] <= wr1_data_i;
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = rd_addr_i[p*AW +: AW];

        always_comb begin
            data = mem_q[addr];
            if (BYPASS != 0) begin
                if (wr1_act && (wr1_addr_i == addr)) begin
                    data = wr1_data_i;
                end else if (wr0_act && (wr0_addr_i == addr)) begin
                    data = wr0_data_i;
                end
            end
            if (!run || (addr == '0)) data = '0;
        end

        assign rd_data_o[p*XLEN +: XLEN] = data;
    end

    riscv_rf_scoreboard #(
        .NREG (NREG),
        .NRP  (NRP)
    ) u_sb (
        .clk         (clk),
        .rstn        (rstn),
        .set_en_i    (rstn && run && sb_set_en_i),
        .set_addr_i  (sb_set_addr_i),
        .clr0_en_i   (wr0_act),
        .clr0_addr_i (wr0_addr_i),
        .clr1_en_i   (wr1_act),
        .clr1_addr_i (wr1_addr_i),
        .rd_addr_i   (rd_addr_i),
        .rd_busy_o   (rd_busy_o)
    );

endmodule

// File: tb/tb_riscv_reg_file_mp.sv
// Scoreboard bench for riscv_reg_file_mp: forwarding and non-forwarding instances.
module tb_riscv_reg_file_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRP  = 2;
    localparam int unsigned AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rstn;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data, rd_data_nb;
    logic [NRP-1:0]      rd_busy, rd_busy_nb;
    logic                wr0_en, wr1_en;
    logic [AW-1:0]       wr0_addr, wr1_addr;
    logic [XLEN-1:0]     wr0_data, wr1_data;
    logic                sb_set_en;
    logic [AW-1:0]       sb_set_addr;
    logic                ready, ready_nb;

    riscv_reg_file_mp #(
        .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(1)
    ) dut (
        .clk(clk), .rstn(rstn), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .rd_busy_o(rd_busy), .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr),
        .wr0_data_i(wr0_data), .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr),
        .wr1_data_i(wr1_data), .sb_set_en_i(sb_set_en), .sb_set_addr_i(sb_set_addr),
        .ready_o(ready)
    );

    riscv_reg_file_mp #(
        .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .rstn(rstn), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb),
        .rd_busy_o(rd_busy_nb), .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr),
        .wr0_data_i(wr0_data), .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr),
        .wr1_data_i(wr1_data), .sb_set_en_i(sb_set_en), .sb_set_addr_i(sb_set_addr),
        .ready_o(ready_nb)
    );

    typedef enum int {KRd, KRdNb, KBusy, KReady} kind_e;
    typedef struct {
        string           tag;
        kind_e           kind;
        int              port;
        logic [XLEN-1:0] exp;
    } exp_t;

    exp_t            sb_q[$];
    int              n_checks = 0;
    int              n_errors = 0;
    logic [XLEN-1:0] ref_mem [NREG];
    int              ref_cnt = 0;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] obs,
                            input logic [XLEN-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input kind_e k, input int port,
                              input logic [XLEN-1:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = k;
        e.port = port;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    function automatic logic [XLEN-1:0] observe(input kind_e k, input int port);
        case (k)
            KRd:     return rd_data[port*XLEN +: XLEN];
            KRdNb:   return rd_data_nb[port*XLEN +: XLEN];
            KBusy:   return XLEN'(rd_busy[port]);
            default: return XLEN'(ready);
        endcase
    endfunction

    // Expected read from the reference array, with optional same-cycle forwarding.
    function automatic logic [XLEN-1:0] model_rd(input logic [AW-1:0] a, input bit byp);
        if (a == '0) return '0;
        if (byp && wr1_en && (wr1_addr == a)) return wr1_data;
        if (byp && wr0_en && (wr0_addr == a)) return wr0_data;
        return ref_mem[a];
    endfunction

    // Compare pending expectations mid-cycle, then advance the model at the edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.kind, e.port), e.exp);
        end
        @(posedge clk);
        if (!rstn) begin
            ref_cnt = 0;
        end else if (ref_cnt < NREG) begin
            ref_mem[ref_cnt] = '0;
            ref_cnt++;
        end else begin
            if (wr0_en) ref_mem[wr0_addr] = wr0_data;
            if (wr1_en) ref_mem[wr1_addr] = wr1_data;
            ref_mem[0] = '0;
        end
        #1;
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic wr0(input int a, input logic [XLEN-1:0] d);
        wr0_en = 1'b1; wr0_addr = AW'(a); wr0_data = d;
    endtask

    task automatic wr1(input int a, input logic [XLEN-1:0] d);
        wr1_en = 1'b1; wr1_addr = AW'(a); wr1_data = d;
    endtask

    // Starts on the cycle rstn has just gone high; writes and sets during INIT must vanish.
    task automatic sweep_check(input string tag);
        for (int k = 0; k <= NREG + 1; k++) begin
            idle();
            if (k == 5) begin
                wr0(9, 32'h0000_AAAA);
                sb_set_en = 1'b1; sb_set_addr = AW'(9);
            end
            set_rd(9, 10);
            expect_val({tag, "_ready"}, KReady, 0, XLEN'(k >= NREG));
            expect_val({tag, "_rd0"}, KRd, 0, 32'h0);
            expect_val({tag, "_rd1"}, KRd, 1, 32'h0);
            expect_val({tag, "_busy0"}, KBusy, 0, 32'h0);
            expect_val({tag, "_busy1"}, KBusy, 1, 32'h0);
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) ref_mem[i] = '0;
        rstn = 1'b0;
        idle();
        set_rd(0, 0);
        step();
        step();
        rstn = 1'b1;
        sweep_check("init");

        wr0(5, 32'hDEAD_BEEF); set_rd(5, 5);
        expect_val("x5_same_byp", KRd, 0, 32'hDEAD_BEEF);
        expect_val("x5_same_nobyp", KRdNb, 0, 32'h0);
        step(); idle();
        expect_val("x5_p0", KRd, 0, 32'hDEAD_BEEF);
        expect_val("x5_p1", KRd, 1, 32'hDEAD_BEEF);
        expect_val("x5_nb_p1", KRdNb, 1, 32'hDEAD_BEEF);
        step();

        wr0(0, 32'h1234); set_rd(0, 0);
        expect_val("x0_same", KRd, 0, 32'h0);
        step(); idle();
        expect_val("x0_p0", KRd, 0, 32'h0);
        expect_val("x0_p1", KRd, 1, 32'h0);
        step();

        wr0(7, 32'h11); wr1(7, 32'h22); set_rd(7, 7);
        expect_val("x7_same_p0", KRd, 0, 32'h22);
        expect_val("x7_same_p1", KRd, 1, 32'h22);
        expect_val("x7_same_nb", KRdNb, 0, 32'h0);
        step(); idle();
        expect_val("x7_after", KRd, 0, 32'h22);
        expect_val("x7_after_nb", KRdNb, 0, 32'h22);
        step();
        wr0(7, 32'h33); wr1(7, 32'h44);
        expect_val("x7_same2", KRd, 0, 32'h44);
        expect_val("x7_same2_nb", KRdNb, 0, 32'h22);
        step(); idle();
        expect_val("x7_after2", KRd, 1, 32'h44);
        expect_val("x7_after2_nb", KRdNb, 1, 32'h44);
        step();
        wr0(8, 32'h55); wr1(9, 32'h66); set_rd(8, 9);
        expect_val("x8_byp", KRd, 0, 32'h55);
        expect_val("x9_byp", KRd, 1, 32'h66);
        step(); idle();
        expect_val("x8_after", KRd, 0, 32'h55);
        expect_val("x9_after", KRd, 1, 32'h66);
        step();

        sb_set_en = 1'b1; sb_set_addr = AW'(3); set_rd(3, 4);
        expect_val("busy3_same_set", KBusy, 0, 32'h0);
        step(); idle();
        expect_val("busy3_set", KBusy, 0, 32'h1);
        expect_val("busy4_clear", KBusy, 1, 32'h0);
        step();
        wr1(3, 32'h77); set_rd(3, 3);
        expect_val("busy3_same_clr", KBusy, 0, 32'h1);
        step(); idle();
        expect_val("busy3_cleared", KBusy, 0, 32'h0);
        expect_val("x3_data", KRd, 1, 32'h77);
        step();
        sb_set_en = 1'b1; sb_set_addr = AW'(3); wr0(3, 32'h88);
        step(); idle();
        expect_val("busy3_set_wins", KBusy, 0, 32'h1);
        expect_val("x3_data2", KRd, 1, 32'h88);
        step();
        sb_set_en = 1'b1; sb_set_addr = AW'(0); set_rd(0, 3);
        step(); idle();
        expect_val("busy0", KBusy, 0, 32'h0);
        expect_val("busy3_held", KBusy, 1, 32'h1);
        step();
        wr0(3, 32'h99);
        step(); idle();
        expect_val("busy3_wr0_clr", KBusy, 1, 32'h0);
        step();

        for (int i = 0; i < 24; i++) begin
            idle();
            wr0_en = 1'($urandom_range(0, 1));
            wr0_addr = AW'($urandom_range(0, 7));
            wr0_data = $urandom;
            wr1_en = 1'($urandom_range(0, 1));
            wr1_addr = AW'($urandom_range(0, 7));
            wr1_data = $urandom;
            set_rd($urandom_range(0, 7), $urandom_range(0, 7));
            expect_val("rand_p0", KRd, 0, model_rd(rd_addr[AW-1:0], 1'b1));
            expect_val("rand_p1", KRd, 1, model_rd(rd_addr[2*AW-1:AW], 1'b1));
            expect_val("rand_nb", KRdNb, 0, model_rd(rd_addr[AW-1:0], 1'b0));
            step();
        end

        idle();
        sb_set_en = 1'b1; sb_set_addr = AW'(10);
        step(); idle(); set_rd(10, 3);
        expect_val("busy10_pre", KBusy, 0, 32'h1);
        expect_val("ready_pre", KReady, 0, 32'h1);
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            expect_val("ready_partial", KReady, 0, 32'h0);
            step();
        end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        sweep_check("rst");
        set_rd(5, 7);
        expect_val("x5_swept", KRd, 0, 32'h0);
        expect_val("x7_swept", KRd, 1, 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_reg_file_mp.md
RISCV_REG_FILE_MP -- requirements
Module: riscv_reg_file_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning register count, a power of two of at least 2; AW = clog2(NREG).
REQ-003 The block SHALL have parameter NRP, default 2, meaning number of read ports, from 1 to 4.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding and 0 = none.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 rstn  input  1  reset, synchronous, active-low.
REQ-007 rd_addr  input  NRP*AW  read addresses; port p SHALL use bits [p*AW +: AW].
REQ-008 rd_data  output  NRP*XLEN  combinational read data for each port.
REQ-009 rd_busy  output  NRP  scoreboard busy bit of each read address.
REQ-010 wr0_en, wr1_en  input  1  write-port enables.
REQ-011 wr0_addr, wr1_addr  input  AW  write addresses.
REQ-012 wr0_data, wr1_data  input  XLEN  write data.
REQ-013 sb_set_en  input  1  marks register sb_set_addr as pending a write.
REQ-014 sb_set_addr  input  AW  scoreboard set address.
REQ-015 ready  output  1  high once the init sweep completes.

Function
REQ-016 Register 0 SHALL always read 0; writes to and scoreboard sets of address 0 SHALL be ignored, and rd_busy for address 0 SHALL be 0.
REQ-017 An FSM SHALL have states INIT and RUN; rstn low SHALL force INIT with sweep index 0.
REQ-018 In INIT with rstn high, each cycle SHALL write 0 to the entry at the sweep index and increment the index; the FSM SHALL enter RUN after writing entry NREG-1.
REQ-019 ready SHALL be 0 in INIT and 1 in RUN; ready SHALL rise exactly NREG cycles after rstn goes high.
REQ-020 In INIT, wr0/wr1 and sb_set_en SHALL be ignored, and rd_data SHALL return 0.
REQ-021 In RUN, an enabled write SHALL update the addressed register at the clock edge.
REQ-022 When both write ports target the same address, wr1 SHALL win.
REQ-023 Reads SHALL be combinational, with zero-cycle latency from rd_addr.
REQ-024 With BYPASS=1, a read of an address being written in the same cycle SHALL return the write data, applying the REQ-022 priority.
REQ-025 With BYPASS=0, a read of an address being written in the same cycle SHALL return the old value.
REQ-026 The scoreboard SHALL hold NREG busy bits; sb_set_en SHALL set bit[sb_set_addr].
REQ-027 An enabled write in RUN SHALL clear the busy bit of its address.
REQ-028 A set and a clear of the same address in the same cycle SHALL leave the bit set.
REQ-029 rd_busy[p] SHALL equal busy[rd_addr[p]] as registered, with no bypass of same-cycle set or clear.

Reset
REQ-030 rstn low SHALL clear all busy bits, force ready=0, and restart the sweep, including when rstn is asserted mid-sweep or mid-operation.
REQ-031 Register contents SHALL be cleared only by the sweep, not in parallel, so the storage can be inferred as RAM.

Structure
REQ-032 Package riscv_rf_pkg SHALL hold the FSM state enum (RF_INIT, RF_RUN) and the address-width helper function.
REQ-033 The scoreboard SHALL be a sub-module named riscv_rf_scoreboard, parameterised by NREG and NRP.

Verification
REQ-034 Reset is released at cycle 0, NREG=32 -> ready=0 through cycle 31 and 1 from cycle 32; all reads return 0.
REQ-035 In RUN, wr0 writes x5=0xDEADBEEF -> on the next cycle, a read of x5 on every port returns 0xDEADBEEF; a write of 0x1234 to x0 -> x0 still reads 0.
REQ-036 wr0 writes x7=0x11 and wr1 writes x7=0x22 in the same cycle, BYPASS=1 -> same-cycle read of x7 returns 0x22, and it reads 0x22 afterwards; with BYPASS=0 the same-cycle read returns the prior value.
REQ-037 sb_set of x3, then a read of x3 -> rd_busy=1; a wr1 write to x3 -> busy=0 next cycle; a set and a write of x3 in the same cycle -> busy stays 1.
REQ-038 rstn is pulsed low at sweep index 10 -> index restarts at 0, ready rises 32 cycles after release, and busy bits read 0.
